// File: rtl/t05_flv_pkg.sv
// t05_flv_pkg: shared constants, FSM states and address helpers for the FLV scheduler
package t05_flv_pkg;
    localparam int HIST_N   = 256;
    localparam int NODE_N   = 128;
    localparam int DW       = 64;
    localparam int AW       = 9;
    localparam int NODE_BIT = 8;
    localparam logic [AW-1:0] NODE_BASE = AW'(1 << NODE_BIT);

    typedef enum logic [3:0] {
        IDLE, CLEAR, RD_REQ, RD_WAIT, SETTLE, WR_NODE, WIPE1, WIPE2, ARB, FINISH
    } state_t;

    function automatic logic [AW-1:0] node_addr(input logic [7:0] cnt);
        return NODE_BASE + AW'(cnt);
    endfunction
endpackage

// File: rtl/t05_flv_port_mux.sv
// t05_flv_port_mux: selects the SRAM request fields from the scan engine or the HTREE requester
module t05_flv_port_mux
    import t05_flv_pkg::*;
(
    input  logic          sel,
    input  logic          eng_req,
    input  logic          eng_wr,
    input  logic [AW-1:0] eng_addr,
    input  logic [DW-1:0] eng_wdata,
    input  logic          ht_req,
    input  logic          ht_wr,
    input  logic [AW-1:0] ht_addr,
    input  logic [DW-1:0] ht_wdata,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata
);
    assign mem_req   = sel ? ht_req   : eng_req;
    assign mem_wr    = sel ? ht_wr    : eng_wr;
    assign mem_addr  = sel ? ht_addr  : eng_addr;
    assign mem_wdata = sel ? ht_wdata : eng_wdata;
endmodule

// File: rtl/t05_flv_scheduler.sv
// t05_flv_scheduler: sequences find-least-value passes for the Huffman build; optional watchdog under T05_FLV_TIMEOUT_EN
module t05_flv_scheduler
    import t05_flv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          cmp_clear,
    output logic          cmp_valid,
    output logic [DW-1:0] cmp_val,
    output logic [AW-1:0] cmp_idx,
    input  logic [AW-1:0] cmp_least1,
    input  logic [AW-1:0] cmp_least2,
    input  logic [DW-1:0] cmp_sum,
    input  logic          cmp_have2,
    input  logic          ht_req,
    input  logic          ht_wr,
    input  logic [AW-1:0] ht_addr,
    input  logic [DW-1:0] ht_wdata,
    output logic          ht_gnt,
    output logic [7:0]    node_cnt,
    output logic          busy,
    output logic          htree_complete,
    output logic          err
);
    state_t        state, state_nx;
    logic [AW-1:0] idx, l1, l2, eng_addr;
    logic [DW-1:0] sum_q, eng_wdata;
    logic          eng_act, eng_req, eng_wr, sel, timeout, last, node_full, start_ok;

    assign last      = idx == AW'(HIST_N) + AW'(node_cnt) - 1'b1;
    assign node_full = node_cnt == 8'(NODE_N);
    assign start_ok  = state == IDLE && state_nx == CLEAR;

`ifdef T05_FLV_TIMEOUT_EN
    logic [7:0] wd;
    assign timeout = wd == 8'hFF;
    // watchdog counts stalled requests and read waits, clearing whenever the engine makes progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wd <= '0;
        else      wd <= ((eng_act && !mem_gnt) || (state == RD_WAIT && !mem_rvalid)) ? wd + 1'b1 : '0;
    end
`else
    assign timeout = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // next-state logic; a pending HTREE request in IDLE must be granted before a build may start
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (start && (!ht_req || mem_gnt)) ? CLEAR : IDLE;
            CLEAR:   state_nx = RD_REQ;
            RD_REQ:  state_nx = mem_gnt ? RD_WAIT : RD_REQ;
            RD_WAIT: state_nx = !mem_rvalid ? RD_WAIT : last ? SETTLE : RD_REQ;
            SETTLE:  state_nx = (!cmp_have2 || node_full) ? FINISH : WR_NODE;
            WR_NODE: state_nx = mem_gnt ? WIPE1 : WR_NODE;
            WIPE1:   state_nx = mem_gnt ? WIPE2 : WIPE1;
            WIPE2:   state_nx = mem_gnt ? ARB : WIPE2;
            ARB:     state_nx = ht_req ? ARB : CLEAR;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (timeout) state_nx = FINISH;
    end

    // outputs decoded from state; the engine request is dropped the moment the watchdog fires
    always_comb begin
        eng_act   = state inside {RD_REQ, WR_NODE, WIPE1, WIPE2};
        eng_req   = eng_act && !timeout;
        eng_wr    = state inside {WR_NODE, WIPE1, WIPE2};
        eng_addr  = state == RD_REQ  ? idx :
                    state == WR_NODE ? node_addr(node_cnt) :
                    state == WIPE1   ? l1 :
                    state == WIPE2   ? l2 : '0;
        eng_wdata = state == WR_NODE ? sum_q : '0;
        cmp_clear = state == CLEAR;
        cmp_valid = state == RD_WAIT && mem_rvalid && |mem_rdata;
        cmp_val   = cmp_valid ? mem_rdata : '0;
        cmp_idx   = cmp_valid ? idx : '0;
        busy      = state != IDLE && state != FINISH;
        sel       = ht_req && (state == IDLE || state == ARB);
        ht_gnt    = sel && mem_gnt;
    end

    // scan index, latched comparator result, node count and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx            <= '0;
            l1             <= '0;
            l2             <= '0;
            sum_q          <= '0;
            node_cnt       <= '0;
            err            <= 1'b0;
            htree_complete <= 1'b0;
        end else begin
            if (state == CLEAR) idx <= '0;
            else if (state == RD_WAIT && mem_rvalid) idx <= idx + 1'b1;
            if (state == SETTLE) begin
                l1    <= cmp_least1;
                l2    <= cmp_least2;
                sum_q <= cmp_sum;
            end
            if (start_ok) node_cnt <= '0;
            else if (state == WIPE2 && mem_gnt) node_cnt <= node_cnt + 1'b1;
            if (start_ok) err <= 1'b0;
            else if ((state == SETTLE && cmp_have2 && node_full) || timeout) err <= 1'b1;
            if (start_ok) htree_complete <= 1'b0;
            else if (state_nx == FINISH) htree_complete <= 1'b1;
        end
    end

    t05_flv_port_mux u_mux (
        .sel       (sel),
        .eng_req   (eng_req),
        .eng_wr    (eng_wr),
        .eng_addr  (eng_addr),
        .eng_wdata (eng_wdata),
        .ht_req    (ht_req),
        .ht_wr     (ht_wr),
        .ht_addr   (ht_addr),
        .ht_wdata  (ht_wdata),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );
endmodule
